// File: rtl/writeback_register_file_pkg.sv
// Shared processor constants for the write-back / register-file slice.
//   DATA_WIDTH_DEF : default register and data width in bits
//   ADDR_WIDTH_DEF : default register-address width (2**ADDR_WIDTH registers)
//   ZERO_REG       : index of the hard-wired zero register
package writeback_register_file_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int ZERO_REG       = 0;
endpackage

// File: rtl/writeback_register_file_if.sv
// MEM/WB + register-file bus.
//   i_* : driven by the pipeline (master) into the register file (slave)
//   o_* : driven by the register file back to the pipeline
//   stall/flush control, MEM-stage candidates, read addresses in;
//   raw read data and staged write-back tuple out.
interface writeback_register_file_if
  import writeback_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  i_stall;
  logic                  i_flush;
  logic                  i_mem_to_reg;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic [DATA_WIDTH-1:0] i_mem_read_data;
  logic [ADDR_WIDTH-1:0] i_dest_register;
  logic                  i_reg_write_in;
  logic [ADDR_WIDTH-1:0] i_read_register1;
  logic [ADDR_WIDTH-1:0] i_read_register2;
  logic [DATA_WIDTH-1:0] o_read_data1;
  logic [DATA_WIDTH-1:0] o_read_data2;
  logic [ADDR_WIDTH-1:0] o_write_register;
  logic [DATA_WIDTH-1:0] o_write_data;
  logic                  o_register_write;

  modport master (
    output i_stall, i_flush, i_mem_to_reg, i_alu_result, i_mem_read_data,
           i_dest_register, i_reg_write_in, i_read_register1, i_read_register2,
    input  o_read_data1, o_read_data2, o_write_register, o_write_data,
           o_register_write
  );

  modport slave (
    input  i_stall, i_flush, i_mem_to_reg, i_alu_result, i_mem_read_data,
           i_dest_register, i_reg_write_in, i_read_register1, i_read_register2,
    output o_read_data1, o_read_data2, o_write_register, o_write_data,
           o_register_write
  );
endinterface

// File: rtl/mem_wb_stage_register.sv
// MEM/WB pipeline stage register.
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_stall, i_flush    : hold / load bubble (flush wins over stall)
//   i_reg_write, i_dest, i_data : write-back tuple from MEM
//   o_reg_write, o_dest, o_data : staged write-back tuple
module mem_wb_stage_register
  import writeback_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_reg_write,
  input  logic [ADDR_WIDTH-1:0] i_dest,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_reg_write,
  output logic [ADDR_WIDTH-1:0] o_dest,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic                  r_reg_write;
  logic [ADDR_WIDTH-1:0] r_dest;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reg_write <= 1'b0;
      r_dest      <= '0;
      r_data      <= '0;
    end else if (i_flush) begin
      r_reg_write <= 1'b0;
      r_dest      <= '0;
      r_data      <= '0;
    end else if (!i_stall) begin
      r_reg_write <= i_reg_write;
      r_dest      <= i_dest;
      r_data      <= i_data;
    end
  end

  assign o_reg_write = r_reg_write;
  assign o_dest      = r_dest;
  assign o_data      = r_data;
endmodule

// File: rtl/writeback_register_file.sv
// Write-back stage plus architectural register file.
//   i_clk, i_rst_n : clock, async active-low reset (clears stage and array)
//   bus (slave)    : MEM-stage inputs, read addresses, read data and the
//                    staged write-back tuple (see writeback_register_file_if)
// Reads are raw array contents; same-cycle bypass is left to the forwarding
// unit, so a read of the register being written returns the old value.
module writeback_register_file
  import writeback_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  writeback_register_file_if.slave bus
);
  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] w_mem_data;
  logic                  w_wb_we;
  logic [ADDR_WIDTH-1:0] w_wb_addr;
  logic [DATA_WIDTH-1:0] w_wb_data;
  logic [DATA_WIDTH-1:0] r_regs [NREG];

  assign w_mem_data = bus.i_mem_to_reg ? bus.i_mem_read_data : bus.i_alu_result;

  mem_wb_stage_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem_wb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_stall     (bus.i_stall),
    .i_flush     (bus.i_flush),
    .i_reg_write (bus.i_reg_write_in),
    .i_dest      (bus.i_dest_register),
    .i_data      (w_mem_data),
    .o_reg_write (w_wb_we),
    .o_dest      (w_wb_addr),
    .o_data      (w_wb_data)
  );

  // The array writes from the stage's current contents on the same edge the
  // stage captures new MEM inputs, giving two edges from MEM to array.
  // A stalled stage simply rewrites the same value each edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wb_we && (w_wb_addr != ZERO_ADDR)) begin
      r_regs[w_wb_addr] <= w_wb_data;
    end
  end

  // Entry 0 is never written, but the read mux forces zero regardless.
  assign bus.o_read_data1 = (bus.i_read_register1 == ZERO_ADDR) ? '0 : r_regs[bus.i_read_register1];
  assign bus.o_read_data2 = (bus.i_read_register2 == ZERO_ADDR) ? '0 : r_regs[bus.i_read_register2];

  assign bus.o_write_register = w_wb_addr;
  assign bus.o_write_data     = w_wb_data;
  assign bus.o_register_write = w_wb_we;
endmodule

// File: tb/tb_writeback_register_file.sv
module tb_writeback_register_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  writeback_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) wb_if ();

  writeback_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (wb_if)
  );

  // Reference: register contents as an array and the in-flight write-back
  // as one pending tuple that lands in the array on the following edge.
  logic [31:0] m_regs [32];
  logic        m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] <= 32'h0;
      m_we <= 1'b0; m_wr <= 5'd0; m_wd <= 32'h0;
    end else begin
      if (m_we && m_wr != 5'd0) m_regs[m_wr] <= m_wd;
      if (wb_if.i_flush) begin
        m_we <= 1'b0; m_wr <= 5'd0; m_wd <= 32'h0;
      end else if (!wb_if.i_stall) begin
        m_we <= wb_if.i_reg_write_in;
        m_wr <= wb_if.i_dest_register;
        m_wd <= wb_if.i_mem_to_reg ? wb_if.i_mem_read_data : wb_if.i_alu_result;
      end
    end
  end

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : m_regs[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    chk("cmp_we",  {31'd0, wb_if.o_register_write}, {31'd0, m_we});
    chk("cmp_wr",  {27'd0, wb_if.o_write_register}, {27'd0, m_wr});
    chk("cmp_wd",  wb_if.o_write_data, m_wd);
    chk("cmp_rd1", wb_if.o_read_data1, m_read(wb_if.i_read_register1));
    chk("cmp_rd2", wb_if.o_read_data2, m_read(wb_if.i_read_register2));
  end

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] mem, input logic m2r, input logic st, input logic fl);
    wb_if.i_reg_write_in  = we;
    wb_if.i_dest_register = rd;
    wb_if.i_alu_result    = alu;
    wb_if.i_mem_read_data = mem;
    wb_if.i_mem_to_reg    = m2r;
    wb_if.i_stall         = st;
    wb_if.i_flush         = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rd1(input logic [4:0] a, input string nm, input logic [31:0] exp);
    wb_if.i_read_register1 = a;
    #1;
    chk(nm, wb_if.o_read_data1, exp);
  endtask

  initial begin
    idle();
    wb_if.i_read_register1 = 5'd0;
    wb_if.i_read_register2 = 5'd0;

    // Reset: all 32 addresses read zero, stage clear.
    #2;
    for (int a = 0; a < 32; a++) begin
      wb_if.i_read_register1 = a[4:0];
      wb_if.i_read_register2 = 5'(31 - a);
      #0.1;
      chk("reset_rd1", wb_if.o_read_data1, 32'h0);
      chk("reset_rd2", wb_if.o_read_data2, 32'h0);
    end
    chk("reset_we", {31'd0, wb_if.o_register_write}, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // ALU result write-back, two-edge latency.
    drive(1'b1, 5'd5, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("alu_wr", {27'd0, wb_if.o_write_register}, 32'd5);
    chk("alu_wd", wb_if.o_write_data, 32'h12345678);
    chk("alu_we", {31'd0, wb_if.o_register_write}, 32'd1);
    rd1(5'd5, "alu_old_value", 32'h0);
    tick();
    rd1(5'd5, "alu_visible", 32'h12345678);
    chk("model_pin_r5", m_regs[5], 32'h12345678);

    // Memory data to register 0 is staged but discarded.
    drive(1'b1, 5'd0, 32'h11111111, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    chk("mem_wd", wb_if.o_write_data, 32'hDEADBEEF);
    tick();
    rd1(5'd0, "zero_reg", 32'h0);

    // Stall+flush: flush wins, register 7 keeps its prior value.
    drive(1'b1, 5'd7, 32'h00000077, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 32'h00000099, 32'h0, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    chk("flush_we", {31'd0, wb_if.o_register_write}, 32'd0);
    chk("flush_wr", {27'd0, wb_if.o_write_register}, 32'd0);
    chk("flush_wd", wb_if.o_write_data, 32'h0);
    tick();
    rd1(5'd7, "flush_r7", 32'h00000077);

    // Stall for three cycles holding {1, 9, A5A5A5A5}; new inputs ignored.
    drive(1'b1, 5'd9, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_we", {31'd0, wb_if.o_register_write}, 32'd1);
      chk("stall_wr", {27'd0, wb_if.o_write_register}, 32'd9);
      chk("stall_wd", wb_if.o_write_data, 32'hA5A5A5A5);
      rd1(5'd9, "stall_r9", 32'hA5A5A5A5);
    end
    idle();
    tick();
    chk("unstall_we", {31'd0, wb_if.o_register_write}, 32'd0);
    tick();
    rd1(5'd3, "stall_ignored_r3", 32'h0);

    // Reset between the two edges aborts the pending write to register 5.
    drive(1'b1, 5'd5, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_rst_we", {31'd0, wb_if.o_register_write}, 32'd1);
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_we", {31'd0, wb_if.o_register_write}, 32'd0);
    chk("rst_wr", {27'd0, wb_if.o_write_register}, 32'd0);
    chk("rst_wd", wb_if.o_write_data, 32'h0);
    rd1(5'd5, "rst_r5", 32'h0);
    #1 rst_n = 1'b1;
    tick();
    tick();
    rd1(5'd5, "post_rst_r5", 32'h0);

    // Randomized traffic with occasional stall, flush and reset pulses.
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom, $urandom,
            1'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
      wb_if.i_read_register1 = 5'($urandom);
      wb_if.i_read_register2 = (c % 3 == 0) ? wb_if.i_dest_register : 5'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
